// File: rtl/truth_table_sweeper_if.sv
// Handshake and datapath bundle between the truth-table sweeper and its client.
// The sweeper sits on the slave side; the stimulus/response environment is the master.
interface truth_table_sweeper_if #(
    parameter int SEL_W = 3,
    parameter int IN_W  = 2
);
    localparam int N = 1 << (SEL_W + IN_W);

    logic             start;
    logic             mux_out;
    logic [SEL_W-1:0] sel_out;
    logic [IN_W-1:0]  din_out;
    logic             busy;
    logic             done;
    logic [N-1:0]     result;
    logic             result_valid;

    modport slave (
        input  start,
        input  mux_out,
        output sel_out,
        output din_out,
        output busy,
        output done,
        output result,
        output result_valid
    );

    modport master (
        output start,
        output mux_out,
        input  sel_out,
        input  din_out,
        input  busy,
        input  done,
        input  result,
        input  result_valid
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every {select, decoder-input} combination, holds each for DWELL cycles,
// and captures the mux response from the last cycle of each dwell into a truth table.
module truth_table_sweeper #(
    parameter int DWELL = 20,
    parameter int SEL_W = 3,
    parameter int IN_W  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    truth_table_sweeper_if.slave  bus
);
    localparam int IDX_W = SEL_W + IN_W;
    localparam int N     = 1 << IDX_W;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [N-1:0]     result_q;
    logic             valid_q;

    // idx returns to 0 at the end of a sweep so the select/input lines idle at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        result_q <= '0;
                        valid_q  <= 1'b0;
                        idx_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SWEEP;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SWEEP: begin
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        result_q[idx_q] <= bus.mux_out;
                        cnt_q           <= '0;
                        if (idx_q == IDX_W'(N - 1)) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            valid_q <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.sel_out      = idx_q[IDX_W-1:IN_W];
    assign bus.din_out      = idx_q[IN_W-1:0];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: three sweepers with different dwell times driven by
// table-lookup and formula responders, checked against timing derived from the sweep rules.
module tb_truth_table_sweeper;
    localparam int N = 32;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [31:0] tbl20;
    logic [31:0] tbl1;
    int          cur;

    truth_table_sweeper_if #(.SEL_W(3), .IN_W(2)) if20 ();
    truth_table_sweeper_if #(.SEL_W(3), .IN_W(2)) if3 ();
    truth_table_sweeper_if #(.SEL_W(3), .IN_W(2)) if1 ();

    truth_table_sweeper #(.DWELL(20), .SEL_W(3), .IN_W(2)) dut20 (.clk(clk), .reset(reset), .bus(if20.slave));
    truth_table_sweeper #(.DWELL(3),  .SEL_W(3), .IN_W(2)) dut3  (.clk(clk), .reset(reset), .bus(if3.slave));
    truth_table_sweeper #(.DWELL(1),  .SEL_W(3), .IN_W(2)) dut1  (.clk(clk), .reset(reset), .bus(if1.slave));

    // Responders: two table lookups, and one sel[0] XOR din[1] gate.
    assign if20.mux_out = tbl20[{if20.sel_out, if20.din_out}];
    assign if1.mux_out  = tbl1[{if1.sel_out, if1.din_out}];
    assign if3.mux_out  = if3.sel_out[0] ^ if3.din_out[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  oIdx;
    logic        oBusy;
    logic        oDone;
    logic [31:0] oResult;
    logic        oValid;

    // Observation mux so one sweep routine can drive whichever instance is selected.
    always_comb begin
        oIdx    = '0;
        oBusy   = 1'b0;
        oDone   = 1'b0;
        oResult = '0;
        oValid  = 1'b0;
        case (cur)
            0: begin
                oIdx = {if20.sel_out, if20.din_out}; oBusy = if20.busy; oDone = if20.done;
                oResult = if20.result; oValid = if20.result_valid;
            end
            1: begin
                oIdx = {if3.sel_out, if3.din_out}; oBusy = if3.busy; oDone = if3.done;
                oResult = if3.result; oValid = if3.result_valid;
            end
            default: begin
                oIdx = {if1.sel_out, if1.din_out}; oBusy = if1.busy; oDone = if1.done;
                oResult = if1.result; oValid = if1.result_valid;
            end
        endcase
    end

    task automatic setStart(input logic v);
        case (cur)
            0:       if20.start = v;
            1:       if3.start  = v;
            default: if1.start  = v;
        endcase
    endtask

    function automatic logic [31:0] xorModel();
        logic [31:0] t;
        t = '0;
        for (int k = 0; k < N; k++) t[k] = ((k >> 2) & 1) ^ ((k >> 1) & 1);
        return t;
    endfunction

    // Runs one sweep from the start edge to the done cycle. Caller is #1 after a posedge.
    // Checks per-cycle index stepping, busy, done timing at exactly N*dwell edges, and the table.
    task automatic runSweep(input int dwell, input logic [31:0] expected, input bit alreadyStarted,
                            input bit keepStart, input int pulseAt, input string tag);
        int  c;
        bit  seenDone;
        if (!alreadyStarted) begin
            setStart(1'b1);
            @(posedge clk); #1;
        end
        if (!keepStart) setStart(1'b0);
        c = 0;
        seenDone = 0;
        while (c <= N * dwell + 5) begin
            if (oDone === 1'b1) begin
                seenDone = 1;
                break;
            end
            checks++;
            if (oBusy !== 1'b1 || oIdx !== 5'(c / dwell)) begin
                failures++;
                $display("[TB] FAIL %s step c=%0d busy=%b idx=%0d required busy=1 idx=%0d",
                         tag, c, oBusy, oIdx, c / dwell);
            end
            if (pulseAt >= 0 && c == pulseAt) setStart(1'b1);
            if (pulseAt >= 0 && c == pulseAt + 1) setStart(1'b0);
            @(posedge clk); #1;
            c++;
        end
        checks++;
        if (!seenDone || c != N * dwell) begin
            failures++;
            $display("[TB] FAIL %s done_time got=%0d seen=%0d required=%0d", tag, c, seenDone, N * dwell);
        end
        checks++;
        if (oResult !== expected || oValid !== 1'b1 || oBusy !== 1'b0 || oIdx !== 5'd0) begin
            failures++;
            $display("[TB] FAIL %s done_state result=%h valid=%b busy=%b idx=%0d required result=%h valid=1 busy=0 idx=0",
                     tag, oResult, oValid, oBusy, oIdx, expected);
        end
        if (!keepStart) begin
            @(posedge clk); #1;
            checks++;
            if (oDone !== 1'b0 || oBusy !== 1'b0 || oResult !== expected || oValid !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s after_done done=%b busy=%b result=%h valid=%b required done=0 busy=0 result=%h valid=1",
                         tag, oDone, oBusy, oResult, oValid, expected);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cur = i;
            #1;
            checks++;
            if (oIdx !== 5'd0 || oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0 || oValid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset dut=%0d idx=%0d busy=%b done=%b result=%h valid=%b required all 0",
                         i, oIdx, oBusy, oDone, oResult, oValid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_table_sweep();
        cur = 0;
        tbl20 = 32'h03D1C1E9;
        runSweep(20, 32'h03D1C1E9, 0, 0, -1, "fixed_table");
        for (int r = 0; r < 2; r++) begin
            tbl20 = $urandom;
            runSweep(20, tbl20, 0, 0, -1, "random_table");
        end
    endtask

    task automatic test_constant();
        cur = 2;
        tbl1 = 32'hFFFF_FFFF;
        runSweep(1, 32'hFFFF_FFFF, 0, 0, -1, "const_one");
        tbl1 = 32'h0000_0000;
        runSweep(1, 32'h0000_0000, 0, 0, -1, "const_zero");
    endtask

    task automatic test_ordering();
        cur = 1;
        runSweep(3, xorModel(), 0, 0, -1, "ordering");
    endtask

    task automatic test_start_during_sweep();
        cur = 0;
        tbl20 = $urandom;
        runSweep(20, tbl20, 0, 0, 100, "start_busy");
    endtask

    task automatic test_reset_mid_sweep();
        cur = 0;
        tbl20 = $urandom;
        setStart(1'b1);
        @(posedge clk); #1;
        setStart(1'b0);
        repeat (299) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (oIdx !== 5'd0 || oBusy !== 1'b0 || oDone !== 1'b0 || oResult !== 32'd0 || oValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid idx=%0d busy=%b done=%b result=%h valid=%b required all 0",
                     oIdx, oBusy, oDone, oResult, oValid);
        end
        @(posedge clk); #1;
        checks++;
        if (oBusy !== 1'b0 || oIdx !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_idle busy=%b idx=%0d required busy=0 idx=0", oBusy, oIdx);
        end
        runSweep(20, tbl20, 0, 0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        cur = 1;
        runSweep(3, xorModel(), 0, 1, -1, "b2b_first");
        @(posedge clk); #1;
        checks++;
        if (oBusy !== 1'b1 || oDone !== 1'b0 || oValid !== 1'b0 || oResult !== 32'd0 || oIdx !== 5'd0) begin
            failures++;
            $display("[TB] FAIL b2b_restart busy=%b done=%b valid=%b result=%h idx=%0d required busy=1 done=0 valid=0 result=0 idx=0",
                     oBusy, oDone, oValid, oResult, oIdx);
        end
        runSweep(3, xorModel(), 1, 0, -1, "b2b_second");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cur      = 0;
        reset    = 1'b1;
        tbl20    = '0;
        tbl1     = '0;
        if20.start = 1'b0;
        if3.start  = 1'b0;
        if1.start  = 1'b0;
        test_reset();
        test_table_sweep();
        test_constant();
        test_ordering();
        test_start_during_sweep();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
